// File: rtl/spi_ram_slave_p.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_slave_p
// Purpose  : Clock-synchronous SPI-style slave in front of a small RAM.
//            Each frame is: one start edge, 2 command bits, then either a
//            DATA_WIDTH payload (00 wr-addr, 01 wr-data, 10 rd-addr) or a
//            turnaround edge plus DATA_WIDTH MISO cycles (11 rd-data).
// Ports    : clk       - system clock, rising edge
//            rst       - asynchronous active-high reset
//            SS_n      - slave select, active low, frames while low
//            MOSI      - serial data in, sampled on rising clk
//            MISO      - registered serial data out, 0 outside TX
//            frame_err - one-cycle pulse when a frame is aborted
// Options  : define SPI_RAM_BURST_EN to let write-data / read-data frames
//            continue at incrementing (wrapping) addresses while SS_n stays low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ram_slave_p #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  c_last_bit  = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(MEM_DEPTH - 1);
`ifdef SPI_RAM_BURST_EN
  localparam logic c_burst = 1'b1;
`else
  localparam logic c_burst = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, CMD, RX, TURN, TX, DONE} state_t;

  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_shift, w_word, w_rd_word;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [1:0]            r_cmd;
  logic [ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr, r_tx_addr;
  logic [ADDR_WIDTH-1:0] w_wr_next, w_tx_next, w_wr_target, w_rd_sel;
  logic                  r_burst, w_last, w_active, w_err, w_mem_we;

  assign w_last    = (r_cnt == c_last_bit);
  assign w_word    = {r_shift[DATA_WIDTH-2:0], MOSI};
  assign w_wr_next = (r_wr_addr == c_last_addr) ? '0 : r_wr_addr + 1'b1;
  assign w_tx_next = (r_tx_addr == c_last_addr) ? '0 : r_tx_addr + 1'b1;

  // The first word of a write goes to wr_addr; burst continuation words go
  // one past the last written address.
  assign w_wr_target = r_burst ? w_wr_next : r_wr_addr;

  // TURN fetches the first read word, TX completion prefetches the next one.
  assign w_rd_sel  = (r_state == TURN) ? r_rd_addr : w_tx_next;
  assign w_rd_word = mem[w_rd_sel];

  assign w_active = r_state inside {START, CMD, RX, TURN, TX};
  // A burst sitting exactly on a word boundary has nothing half-transferred,
  // so releasing SS_n there is a clean end, not an abort.
  assign w_err    = SS_n && w_active && !(r_burst && (r_cnt == '0));
  assign w_mem_we = !SS_n && (r_state == RX) && w_last && (r_cmd == 2'b01);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!SS_n) w_next = START;
      START:   w_next = CMD;
      CMD:     w_next = ({r_cmd[1], MOSI} == 2'b11) ? TURN : RX;
      RX:      if (w_last && !(c_burst && (r_cmd == 2'b01))) w_next = DONE;
      TURN:    w_next = TX;
      TX:      if (w_last && !c_burst) w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
    if (SS_n) w_next = IDLE;
  end

  // --------------------------------------------------------------------------
  // Datapath: command, payload shifter, addresses, MISO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MISO      <= 1'b0;
      frame_err <= 1'b0;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_tx_addr <= '0;
      r_burst   <= 1'b0;
    end else begin
      frame_err <= w_err;
      if (SS_n) begin
        MISO    <= 1'b0;
        r_cnt   <= '0;
        r_burst <= 1'b0;
      end else begin
        case (r_state)
          START: r_cmd[1] <= MOSI;
          CMD: begin
            r_cmd[0] <= MOSI;
            r_cnt    <= '0;
            r_burst  <= 1'b0;
          end
          RX: begin
            r_shift <= w_word;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
              case (r_cmd)
                2'b00:   r_wr_addr <= w_word[ADDR_WIDTH-1:0];
                2'b10:   r_rd_addr <= w_word[ADDR_WIDTH-1:0];
                2'b01: begin
                  if (c_burst) begin
                    r_wr_addr <= w_wr_target;
                    r_burst   <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
          TURN: begin
            MISO      <= w_rd_word[DATA_WIDTH-1];
            r_shift   <= w_rd_word << 1;
            r_tx_addr <= r_rd_addr;
            r_cnt     <= '0;
          end
          TX: begin
            if (w_last) begin
              r_cnt <= '0;
              if (c_burst) begin
                // rd_addr only advances once a word has been fully shifted out.
                r_rd_addr <= r_tx_addr;
                r_tx_addr <= w_tx_next;
                MISO      <= w_rd_word[DATA_WIDTH-1];
                r_shift   <= w_rd_word << 1;
                r_burst   <= 1'b1;
              end else begin
                MISO <= 1'b0;
              end
            end else begin
              MISO    <= r_shift[DATA_WIDTH-1];
              r_shift <= r_shift << 1;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
          default: MISO <= 1'b0;
        endcase
      end
    end
  end

  // Memory contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem[w_wr_target] <= w_word;
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_slave_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ram_slave_p
// Purpose  : Self-checking bench for spi_ram_slave_p (DATA_WIDTH=8,
//            MEM_DEPTH=256). Keeps a word-level model of the RAM and the two
//            address registers and compares every MISO bit of every read.
//            Honours SPI_RAM_BURST_EN for the burst-wrap expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ram_slave_p;

  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic frame_err;

  always #5 clk = ~clk;

  spi_ram_slave_p #(
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .ADDR_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .frame_err(frame_err)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: memory and the two address pointers.
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  logic [7:0] pool [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive inputs after the falling edge, let the rising edge
  // sample them, return on the next falling edge for checking.
  task automatic cyc(input logic ss, input logic mosi);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame_wr(input logic [1:0] cmd, input logic [7:0] pl);
    cyc(1'b0, 1'($urandom));
    check("start_miso", MISO, 0);
    cyc(1'b0, cmd[1]);
    cyc(1'b0, cmd[0]);
    for (int i = DW - 1; i >= 0; i--) begin
      cyc(1'b0, pl[i]);
      check("wr_miso", MISO, 0);
    end
    cyc(1'b1, 1'($urandom));
    check("wr_end_err", frame_err, 0);
    case (cmd)
      2'b00:   m_wr = pl;
      2'b01:   m_mem[m_wr] = pl;
      2'b10:   m_rd = pl;
      default: ;
    endcase
  endtask

  task automatic frame_rd(input string tag);
    logic [7:0] exp;
    exp = m_mem[m_rd];
    cyc(1'b0, 1'($urandom));
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'($urandom));          // turnaround edge
    check(tag, MISO, exp[7]);
    for (int i = DW - 2; i >= 0; i--) begin
      cyc(1'b0, 1'($urandom));
      check(tag, MISO, exp[i]);
    end
    cyc(1'b0, 1'($urandom));
    check("rd_done_miso", MISO, 0);
    cyc(1'b1, 1'($urandom));
    check("rd_end_err", frame_err, 0);
  endtask

  // Keep SS_n low for 'edges' rising edges (start edge included), then drop it.
  task automatic abort_after(input logic [1:0] cmd, input int edges);
    for (int e = 0; e < edges; e++) begin
      if (e == 1)      cyc(1'b0, cmd[1]);
      else if (e == 2) cyc(1'b0, cmd[0]);
      else             cyc(1'b0, 1'($urandom));
    end
    cyc(1'b1, 1'b0);
    check("abort_err_pulse", frame_err, 1);
    check("abort_miso", MISO, 0);
    cyc(1'b1, 1'b0);
    check("abort_err_clear", frame_err, 0);
  endtask

  task automatic frame_wr_burst(input logic [7:0] p0, input logic [7:0] p1);
    cyc(1'b0, 1'($urandom));
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    for (int i = DW - 1; i >= 0; i--) cyc(1'b0, p0[i]);
    for (int i = DW - 1; i >= 0; i--) begin
      cyc(1'b0, p1[i]);
      check("burst_miso", MISO, 0);
    end
    cyc(1'b1, 1'b0);
    check("burst_end_err", frame_err, 0);
    m_mem[m_wr] = p0;
`ifdef SPI_RAM_BURST_EN
    m_wr = 8'((int'(m_wr) + 1) % DEPTH);
    m_mem[m_wr] = p1;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    m_wr = 8'h00;
    m_rd = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_miso", MISO, 0);
    check("reset_err", frame_err, 0);
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    check("idle_err", frame_err, 0);

    // Preload known words so every later read has a defined expectation.
    frame_wr(2'b00, 8'h00); frame_wr(2'b01, 8'h3C);
    frame_wr(2'b00, 8'hFF); frame_wr(2'b01, 8'h5A);
    for (int k = 0; k < 8; k++) begin
      pool[k] = 8'($urandom);
      frame_wr(2'b00, pool[k]);
      frame_wr(2'b01, 8'($urandom));
    end

    // Basic write then read of 0xA5 at 0x0F: MISO 1,0,1,0,0,1,0,1.
    frame_wr(2'b00, 8'h0F);
    frame_wr(2'b01, 8'hA5);
    frame_wr(2'b10, 8'h0F);
    frame_rd("rd_a5");

    // Aborts at several depths; none may touch memory or addresses.
    abort_after(2'b01, 7);            // write-data after 4 payload bits
    frame_rd("rd_after_abort");
    abort_after(2'b11, 1);            // START
    abort_after(2'b10, 2);            // CMD
    abort_after(2'b11, 5);            // TX
    abort_after(2'b00, 6);            // write-address mid payload
    abort_after(2'b10, 9);            // read-address mid payload
    frame_wr(2'b01, 8'h77);           // still lands at 0x0F
    frame_rd("rd_after_addr_abort");

    // Reset in the middle of a write-data payload.
    frame_wr(2'b10, 8'hFF);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'($urandom));
    rst = 1'b1;
    #1;
    check("midrst_miso", MISO, 0);
    check("midrst_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    check("postrst_err", frame_err, 0);
    cyc(1'b1, 1'b0);
    check("postrst_idle_err", frame_err, 0);
    m_wr = 8'h00;
    m_rd = 8'h00;
    frame_rd("rd_default_addr0");    // rd_addr is 0 after reset
    frame_wr(2'b10, 8'h0F);
    frame_rd("rd_no_write_on_rst");  // 0x0F must still hold 0x77
    frame_wr(2'b01, 8'hC3);          // wr_addr is 0 after reset
    frame_wr(2'b10, 8'h00);
    frame_rd("rd_wr_addr0");

    // Randomized command mix against the model.
    for (int n = 0; n < 40; n++) begin
      case ($urandom % 4)
        0:       frame_wr(2'b00, pool[$urandom % 8]);
        1:       frame_wr(2'b01, 8'($urandom));
        2:       frame_wr(2'b10, pool[$urandom % 8]);
        default: frame_rd("rd_random");
      endcase
    end

    // Two write-data words under one SS_n low, starting at the top address.
    frame_wr(2'b00, 8'hFF);
    frame_wr_burst(8'h11, 8'h22);
    frame_wr(2'b10, 8'hFF);
    frame_rd("rd_burst_ff");
    frame_wr(2'b10, 8'h00);
    frame_rd("rd_burst_00");
    frame_wr(2'b01, 8'h9E);           // lands wherever wr_addr was left
    frame_wr(2'b10, m_wr);
    frame_rd("rd_burst_wr_addr");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_ram_slave_p.md
SPI_RAM_SLAVE_P -- requirements
Module: spi_ram_slave_p

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload and memory word width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, meaning number of memory words.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), meaning address width; ADDR_WIDTH <= DATA_WIDTH is required.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port SS_n  input  1  slave select, active-low; frames while low.
REQ-007 SHALL have port MOSI  input  1  serial data in, sampled on rising clk.
REQ-008 SHALL have port MISO  output  1  serial data out, registered.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on aborted frame.

Function
REQ-010 SHALL implement FSM states IDLE, START, CMD, RX, TURN, TX, DONE.
REQ-011 SHALL go IDLE->START on the first edge SS_n is sampled low; no MOSI bit is captured on that edge.
REQ-012 SHALL capture 2 command bits C[1:0], MSB first, on the next 2 edges (state CMD).
REQ-013 SHALL decode commands: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-014 SHALL, for commands 00/01/10, capture DATA_WIDTH payload bits MSB first in RX.
REQ-015 SHALL load wr_addr (00) or rd_addr (10) with payload[ADDR_WIDTH-1:0] on the edge capturing the last payload bit; upper payload bits are ignored.
REQ-016 SHALL write mem[wr_addr] = payload (01) on the edge capturing the last payload bit; the word is readable from the next cycle.
REQ-017 SHALL, for command 11, spend one TURN edge loading the shift register with mem[rd_addr]; MISO presents bit DATA_WIDTH-1 after that edge and the next lower bit after each following edge, DATA_WIDTH cycles total.
REQ-018 SHALL drive MISO 0 in all states other than TX.
REQ-019 SHALL go to DONE after a frame completes and ignore MOSI there until SS_n is high (burst behaviour per REQ-027).
REQ-020 SHALL return to IDLE on any edge SS_n is sampled high, from any state.
REQ-021 SHALL pulse frame_err for one cycle when SS_n rises in START, CMD, RX, TURN or TX; an aborted write frame leaves mem, wr_addr and rd_addr unchanged.
REQ-022 SHALL serve read-data without a prior read-address from the current rd_addr.
REQ-023 SHALL support back-to-back frames with one SS_n-high cycle between them.

Reset
REQ-024 SHALL on rst force state IDLE, MISO 0, frame_err 0, wr_addr 0, rd_addr 0, shift and bit counters 0, immediately and asynchronously.
REQ-025 SHALL abort a frame in progress on reset with no memory write and no frame_err pulse.
REQ-026 SHALL not reset memory contents.

Configuration
REQ-027 SHALL support macro SPI_RAM_BURST_EN: when defined, after a completed write-data or read-data frame with SS_n still low, each further DATA_WIDTH bits (write) or DATA_WIDTH cycles (read) continue at the address incremented by 1, wrapping MEM_DEPTH-1 -> 0; the incremented address is kept in wr_addr/rd_addr; an incomplete burst word aborts per REQ-021 with no write and leaves completed burst writes in place.
REQ-028 SHALL, when SPI_RAM_BURST_EN is undefined, behave per REQ-019 with no address auto-increment.

Verification (DATA_WIDTH=8, MEM_DEPTH=256)
REQ-029 SHALL cover write: frame 00+0x0F, then frame 01+0xA5 -> mem[0x0F]=0xA5, MISO 0 throughout.
REQ-030 SHALL cover read: frame 10+0x0F, then frame 11 -> after TURN, MISO = 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
REQ-031 SHALL cover abort: frame 01 with SS_n high after 4 payload bits -> frame_err one-cycle pulse, mem[wr_addr] unchanged.
REQ-032 SHALL cover reset: rst pulsed during RX of write-data -> IDLE, MISO 0, no write, frame_err 0.
REQ-033 SHALL cover burst wrap: frame 00+0xFF, then frame 01 with payloads 0x11,0x22 under one SS_n low -> with macro mem[0xFF]=0x11, mem[0x00]=0x22; without macro mem[0x00] unchanged.
REQ-034 SHALL cover default read: rd_addr 0 after reset, frame 11 -> MISO shifts mem[0x00] MSB first.
